monitor_bus_master: RTL
=======================

MONITOR_BUS_MASTER -- requirements
Module: monitor_bus_master

Interface
REQ-001 Parameter SETUP_CYCLES, default 4: clocks of setup before each strobe (1..255).
REQ-002 Parameter STROBE_CYCLES, default 8: clocks clk_rw is held low per phase (1..255).
REQ-003 Parameter HOLD_CYCLES, default 4: clocks after the strobe rises before the phase ends (1..255).
REQ-004 clk_50mhz_in  in  1  sole clock; all logic is on its rising edge.
REQ-005 reset_x  in  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  high when a command can be accepted.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr / cmd_wdata  in  8 each  register address and write data.
REQ-010 rsp_valid  out  1  one-cycle pulse when a transaction completes.
REQ-011 rsp_rdata  out  8  read data, valid while rsp_valid is high.
REQ-012 slot_x_int_x, clk_rw, ax_d, r_wx  out  1 each  card bus pins, driven at pin polarity: select low, strobe low, ax_d 0 = address / 1 = data, r_wx 1 = read.
REQ-013 ad_out  out  8 and ad_oe_x  out  1  multiplexed bus drive; active-low output enable.
REQ-014 ad_in  in  8  multiplexed bus sampled value.
REQ-015 irq_x  in  1  card interrupt, active-low, asynchronous to clk_50mhz_in.
REQ-016 irq_pending  out  1 and irq_ack  in  1  interrupt flag and its clear.

Function
REQ-017 FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE.
REQ-018 cmd_ready SHALL equal (state == IDLE); acceptance is cmd_valid && cmd_ready at a rising edge, latching cmd_write, cmd_addr and cmd_wdata.
REQ-019 Each SETUP, STROBE and HOLD state SHALL last exactly its parameter in clocks, using one shared 8-bit down-counter.
REQ-020 With acceptance at cycle 0, the address phase occupies cycles 1..P and the data phase occupies P+1..2P, where P = SETUP+STROBE+HOLD; DONE is cycle 2P+1 (rsp_valid = 1) and IDLE resumes at 2P+2.
REQ-021 slot_x_int_x SHALL be 0 from A_SETUP through D_HOLD inclusive, and 1 otherwise.
REQ-022 clk_rw SHALL be 0 only in A_STROBE and D_STROBE.
REQ-023 ax_d SHALL be 0 in the A_* states and 1 in the D_* states, DONE and IDLE.
REQ-024 r_wx SHALL equal ~cmd_write in every non-IDLE state, and 1 in IDLE.
REQ-025 Address phase: ad_out = cmd_addr and ad_oe_x = 0.
REQ-026 Write data phase: ad_out = cmd_wdata and ad_oe_x = 0.
REQ-027 Read data phase: ad_oe_x = 1.
REQ-028 On a read, ad_in SHALL be captured on the last D_STROBE clock into rsp_rdata; on a write, rsp_rdata SHALL be 0.
REQ-029 cmd_valid during a transaction SHALL be ignored; back-to-back commands SHALL insert exactly one IDLE cycle.
REQ-030 irq_x SHALL pass through a 2-flop synchronizer.
REQ-031 irq_pending SHALL set on a synchronized falling edge of irq_x and clear on irq_ack.
REQ-032 When the set edge and irq_ack occur in the same cycle, set SHALL win.

Reset
REQ-033 While reset_x = 0, the FSM SHALL be in IDLE immediately, including mid-transaction, with no rsp_valid pulse.
REQ-034 Reset output values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, slot_x_int_x=1, clk_rw=1, ax_d=1, r_wx=1, ad_out=0, ad_oe_x=1, irq_pending=0; synchronizer flops reset to 1.

Configuration
REQ-035 Macro BKM_MASTER_IRQ_EN, when defined, SHALL compile in the synchronizer and the irq_pending logic of REQ-030..REQ-032.
REQ-036 Without BKM_MASTER_IRQ_EN, irq_pending SHALL be constant 0 and irq_x and irq_ack SHALL be unused.

Structure
REQ-037 Shared package bkm_bus_pkg SHALL hold the FSM state enumeration and the bus-pin idle-level constants.
REQ-038 One sub-module, phase_timer (load value, start, done pulse), SHALL implement the counter.
REQ-039 The pad tri-state SHALL remain at the top level, which combines ad_out and ad_oe_x.

Verification
REQ-040 Write: addr 0x12, data 0xA5 -> ad_out 0x12 with ax_d=0 and clk_rw low for cycles 5..12, then 0xA5 with ax_d=1 for cycles 21..28; rsp_valid at cycle 33.
REQ-041 Read: addr 0x03, card drives ad_in 0x5C in D_STROBE -> ad_oe_x=1 during the data phase; rsp_rdata 0x5C at cycle 33.
REQ-042 Back-to-back: cmd_valid held high with two commands -> second acceptance at cycle 34; cmd_valid during busy has no effect.
REQ-043 Reset asserted at cycle 10 of a write -> all pins reach idle values asynchronously; no rsp_valid; the next command runs normally.
REQ-044 IRQ: irq_x falls -> irq_pending=1 within 3 clocks; irq_ack together with a new falling edge -> irq_pending stays 1.
REQ-045 Without BKM_MASTER_IRQ_EN, toggling irq_x -> irq_pending stays 0.
REQ-046 SETUP=STROBE=HOLD=1 -> rsp_valid at cycle 7.

Source files
------------

// File: rtl/bkm_bus_pkg.sv
// bkm_bus_pkg: shared types and constants for the card-bus master.
//   state_e    - transaction FSM states
//   cmd_t      - latched command payload
//   *_IDLE     - pin levels driven whenever no transaction is in flight
//   in_*()     - state classification helpers used by the pin decode
package bkm_bus_pkg;

    localparam int unsigned AD_W  = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_HOLD   = 3'd6,
        DONE     = 3'd7
    } state_e;

    typedef struct packed {
        logic            write;
        logic [AD_W-1:0] addr;
        logic [AD_W-1:0] wdata;
    } cmd_t;

    localparam logic            SLOT_IDLE    = 1'b1;
    localparam logic            CLK_RW_IDLE  = 1'b1;
    localparam logic            AX_D_IDLE    = 1'b1;
    localparam logic            R_WX_IDLE    = 1'b1;
    localparam logic            AD_OE_X_IDLE = 1'b1;
    localparam logic [AD_W-1:0] AD_OUT_IDLE  = '0;

    function automatic logic in_addr(input state_e s);
        return s inside {A_SETUP, A_STROBE, A_HOLD};
    endfunction

    function automatic logic in_data(input state_e s);
        return s inside {D_SETUP, D_STROBE, D_HOLD};
    endfunction

    function automatic logic in_strobe(input state_e s);
        return s inside {A_STROBE, D_STROBE};
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: shared down-counter timing each SETUP/STROBE/HOLD state.
//   clk_i, rst_ni - clock, async active-low reset
//   start_i       - load a new duration (in clocks, 1..255)
//   load_i        - duration to load
//   done_o        - registered pulse during the last clock of the duration
module phase_timer
    import bkm_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_d;

    // Counter holds clocks remaining after the current one; done fires as it reaches zero.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            cnt_d  = load_i - CNT_W'(1);
            done_d = (load_i == CNT_W'(1));
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_o <= done_d;
        end
    end

endmodule

// File: rtl/monitor_bus_master.sv
// monitor_bus_master: command-driven master for a multiplexed 8-bit card bus.
// Each command runs an address phase then a data phase, each made of
// SETUP/STROBE/HOLD intervals, followed by a one-cycle DONE response.
//   clk_50mhz_in, reset_x         - clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata - command handshake
//   rsp_valid, rsp_rdata          - completion pulse and read data
//   slot_x_int_x, clk_rw, ax_d, r_wx - card control pins (pin polarity)
//   ad_out, ad_oe_x, ad_in        - bus drive, active-low enable, sampled bus;
//                                   the pad tri-state is formed above this block
//   irq_x, irq_pending, irq_ack   - card interrupt, compiled in by BKM_MASTER_IRQ_EN
module monitor_bus_master
    import bkm_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned STROBE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 4
) (
    input  logic            clk_50mhz_in,
    input  logic            reset_x,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AD_W-1:0] cmd_addr,
    input  logic [AD_W-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [AD_W-1:0] rsp_rdata,
    output logic            slot_x_int_x,
    output logic            clk_rw,
    output logic            ax_d,
    output logic            r_wx,
    output logic [AD_W-1:0] ad_out,
    output logic            ad_oe_x,
    input  logic [AD_W-1:0] ad_in,
    input  logic            irq_x,
    output logic            irq_pending,
    input  logic            irq_ack
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [AD_W-1:0] rdata_d;
    logic            tmr_start, tmr_done;
    logic [CNT_W-1:0] tmr_load;
    logic            cmd_ready_d, rsp_valid_d, slot_d, clk_rw_d, ax_d_d, r_wx_d, ad_oe_x_d;
    logic [AD_W-1:0] ad_out_d;
    logic            drive_d;

    phase_timer u_timer (
        .clk_i   (clk_50mhz_in),
        .rst_ni  (reset_x),
        .start_i (tmr_start),
        .load_i  (tmr_load),
        .done_o  (tmr_done)
    );

    // Next state plus pin decode from the next state, so registered pins line up with the state.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rdata_d   = rsp_rdata;
        tmr_start = 1'b0;
        tmr_load  = SETUP_LD;

        case (state_q)
            IDLE: if (cmd_valid) begin
                cmd_d     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
                rdata_d   = '0;
                state_d   = A_SETUP;
                tmr_start = 1'b1;
                tmr_load  = SETUP_LD;
            end
            A_SETUP: if (tmr_done) begin
                state_d = A_STROBE; tmr_start = 1'b1; tmr_load = STROBE_LD;
            end
            A_STROBE: if (tmr_done) begin
                state_d = A_HOLD; tmr_start = 1'b1; tmr_load = HOLD_LD;
            end
            A_HOLD: if (tmr_done) begin
                state_d = D_SETUP; tmr_start = 1'b1; tmr_load = SETUP_LD;
            end
            D_SETUP: if (tmr_done) begin
                state_d = D_STROBE; tmr_start = 1'b1; tmr_load = STROBE_LD;
            end
            D_STROBE: if (tmr_done) begin
                state_d = D_HOLD; tmr_start = 1'b1; tmr_load = HOLD_LD;
                // Card data is sampled on the last strobe clock.
                if (!cmd_q.write) rdata_d = ad_in;
            end
            D_HOLD: if (tmr_done) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        drive_d     = in_addr(state_d) || (in_data(state_d) && cmd_d.write);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        slot_d      = (in_addr(state_d) || in_data(state_d)) ? 1'b0 : SLOT_IDLE;
        clk_rw_d    = in_strobe(state_d) ? 1'b0 : CLK_RW_IDLE;
        ax_d_d      = in_addr(state_d) ? 1'b0 : AX_D_IDLE;
        r_wx_d      = (state_d == IDLE) ? R_WX_IDLE : ~cmd_d.write;
        ad_oe_x_d   = drive_d ? 1'b0 : AD_OE_X_IDLE;
        ad_out_d    = in_addr(state_d) ? cmd_d.addr :
                      drive_d          ? cmd_d.wdata : AD_OUT_IDLE;
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            rsp_rdata    <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            slot_x_int_x <= SLOT_IDLE;
            clk_rw       <= CLK_RW_IDLE;
            ax_d         <= AX_D_IDLE;
            r_wx         <= R_WX_IDLE;
            ad_oe_x      <= AD_OE_X_IDLE;
            ad_out       <= AD_OUT_IDLE;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            rsp_rdata    <= rdata_d;
            cmd_ready    <= cmd_ready_d;
            rsp_valid    <= rsp_valid_d;
            slot_x_int_x <= slot_d;
            clk_rw       <= clk_rw_d;
            ax_d         <= ax_d_d;
            r_wx         <= r_wx_d;
            ad_oe_x      <= ad_oe_x_d;
            ad_out       <= ad_out_d;
        end
    end

`ifdef BKM_MASTER_IRQ_EN
    logic irq_s1_q, irq_s2_q, irq_prev_q, pending_q, pending_d, irq_fall;

    assign irq_fall = irq_prev_q & ~irq_s2_q;

    // A new interrupt edge outranks a simultaneous acknowledge.
    always_comb begin
        pending_d = pending_q;
        if (irq_ack)  pending_d = 1'b0;
        if (irq_fall) pending_d = 1'b1;
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
            irq_prev_q <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            irq_s1_q   <= irq_x;
            irq_s2_q   <= irq_s1_q;
            irq_prev_q <= irq_s2_q;
            pending_q  <= pending_d;
        end
    end

    assign irq_pending = pending_q;
`else
    logic unused_irq;
    assign unused_irq  = irq_x ^ irq_ack;
    assign irq_pending = 1'b0;
`endif

endmodule
